// File: rtl/snd_pkg.sv
// snd_pkg: shared state encoding and sizing helpers for the sound DAC modulator
package snd_pkg;
  typedef enum logic [1:0] {
    SILENT    = 2'd0,
    RAMP_UP   = 2'd1,
    RUN       = 2'd2,
    RAMP_DOWN = 2'd3
  } snd_state_e;
  function automatic int mid_of(input int w);
    return 1 << (w - 1);
  endfunction
  function automatic int cnt_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/snd_dsm1.sv
// snd_dsm1: first-order delta-sigma accumulator with registered carry output
module snd_dsm1 #(
  parameter int IN_W = 7
) (
  input  logic            clk,
  input  logic            reset_l,
  input  logic            tick,
  input  logic [IN_W-1:0] level,
  output logic            dac_out
);
  logic [IN_W-1:0] acc;
  logic [IN_W:0]   sum;
  assign sum = {1'b0, acc} + {1'b0, level};
  // carry out of the wrapping accumulator is the bitstream
  always_ff @(posedge clk or negedge reset_l)
    if (!reset_l) begin
      acc     <= '0;
      dac_out <= 1'b0;
    end else if (tick) begin
      acc     <= sum[IN_W-1:0];
      dac_out <= sum[IN_W];
    end
endmodule

// File: rtl/snd_dac_mod.sv
// snd_dac_mod: pop-free 1-bit audio DAC with mute/ramp control
module snd_dac_mod
  import snd_pkg::*;
#(
  parameter int IN_W     = 7,
  parameter int DIV      = 1,
  parameter int RAMP_DIV = 1024
) (
  input  logic            clk,
  input  logic            reset_l,
  input  logic [IN_W-1:0] sample_in,
  input  logic            mute,
  output logic            dac_out,
  output logic            ramp_busy,
  output logic [IN_W-1:0] level
);
  localparam int TW = cnt_w(DIV);
  localparam int RW = cnt_w(RAMP_DIV);
  localparam logic [IN_W-1:0] MID_L  = IN_W'(mid_of(IN_W));
  localparam logic [TW-1:0]   T_LAST = TW'(DIV - 1);
  localparam logic [RW-1:0]   R_LAST = RW'(RAMP_DIV - 1);
  snd_state_e      state, state_nxt;
  logic [TW-1:0]   tcnt;
  logic [RW-1:0]   rcnt;
  logic [IN_W-1:0] samp_q, lvl_nxt, up_lvl, dn_lvl;
  logic            tick, step;
  assign tick   = tcnt == T_LAST;
  assign step   = ramp_busy && rcnt == R_LAST;
  assign up_lvl = level < MID_L ? level + 1'b1 : level > MID_L ? level - 1'b1 : level;
  assign dn_lvl = level != '0 ? level - 1'b1 : level;
  // free-running tick divider
  always_ff @(posedge clk or negedge reset_l)
    if (!reset_l) tcnt <= '0;
    else tcnt <= tick ? '0 : tcnt + 1'b1;
  // level applied on the next tick for the current state
  always_comb
    lvl_nxt = state == RUN               ? samp_q :
              state == SILENT            ? '0     :
              step && state == RAMP_UP   ? up_lvl :
              step && state == RAMP_DOWN ? dn_lvl : level;
  // state register
  always_ff @(posedge clk or negedge reset_l)
    if (!reset_l) state <= SILENT;
    else state <= state_nxt;
  // mute toggles take priority over terminal-level transitions
  always_comb begin
    state_nxt = state;
    if (tick)
      case (state)
        SILENT:    state_nxt = mute ? SILENT : RAMP_UP;
        RAMP_UP:   state_nxt = mute ? RAMP_DOWN : lvl_nxt == MID_L ? RUN : RAMP_UP;
        RUN:       state_nxt = mute ? RAMP_DOWN : RUN;
        RAMP_DOWN: state_nxt = !mute ? RAMP_UP : lvl_nxt == '0 ? SILENT : RAMP_DOWN;
        default:   state_nxt = SILENT;
      endcase
  end
  // busy flag straight from state
  always_comb ramp_busy = state == RAMP_UP || state == RAMP_DOWN;
  // sample capture, level update and ramp step counter, all on tick
  always_ff @(posedge clk or negedge reset_l)
    if (!reset_l) begin
      samp_q <= '0;
      level  <= '0;
      rcnt   <= '0;
    end else if (tick) begin
      samp_q <= sample_in;
      level  <= lvl_nxt;
      rcnt   <= (state_nxt != state || !ramp_busy || rcnt == R_LAST) ? '0 : rcnt + 1'b1;
    end
  snd_dsm1 #(.IN_W(IN_W)) u_dsm (
    .clk     (clk),
    .reset_l (reset_l),
    .tick    (tick),
    .level   (level),
    .dac_out (dac_out)
  );
endmodule

// File: tb/tb_snd_dac_mod.sv
// tb_snd_dac_mod: directed checks of ramp, modulation density, mute and reset behaviour
module tb_snd_dac_mod;
  logic       clk = 1'b0;
  logic       reset_l, mute;
  logic [6:0] sample_in, samp3;
  logic       dac_out, ramp_busy, dac3, busy3;
  logic [6:0] level, lvl3;
  int n_cmp = 0;
  int n_bad = 0;
  typedef struct {
    logic [6:0] samp;
    int         lvl;
    int         ones;
  } vec_t;
  vec_t tv[5];
  always #5 clk = ~clk;
  snd_dac_mod #(.IN_W(7), .DIV(1), .RAMP_DIV(4)) dut (
    .clk(clk), .reset_l(reset_l), .sample_in(sample_in), .mute(mute),
    .dac_out(dac_out), .ramp_busy(ramp_busy), .level(level)
  );
  snd_dac_mod #(.IN_W(7), .DIV(3), .RAMP_DIV(4)) dut3 (
    .clk(clk), .reset_l(reset_l), .sample_in(samp3), .mute(mute),
    .dac_out(dac3), .ramp_busy(busy3), .level(lvl3)
  );
  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic edge1();
    @(posedge clk);
    #1;
  endtask
  initial begin
    int n, ones, mn, first, badpos;
    logic prev;
    tv[0] = '{7'd32,  32,  32};
    tv[1] = '{7'd0,   0,   0};
    tv[2] = '{7'd127, 127, 127};
    tv[3] = '{7'd64,  64,  64};
    tv[4] = '{7'd100, 100, 100};
    reset_l = 1'b0; mute = 1'b0; sample_in = 7'd32; samp3 = 7'd96;
    #3;
    chk("rst_level", level, 0);
    chk("rst_dac", dac_out, 0);
    chk("rst_busy", ramp_busy, 0);
    @(posedge clk);
    #3 reset_l = 1'b1;
    for (n = 1; n <= 400; n++) begin
      edge1();
      if (n == 1) chk("busy_after_tick1", ramp_busy, 1);
      if (level == 7'd64) break;
    end
    chk("ramp_up_ticks", n, 257);
    chk("run_busy", ramp_busy, 0);
    for (int v = 0; v < 5; v++) begin
      sample_in = tv[v].samp;
      repeat (4) edge1();
      chk($sformatf("run_level_%0d", v), level, tv[v].lvl);
      ones = 0;
      for (int i = 0; i < 128; i++) begin
        edge1();
        ones += dac_out;
      end
      chk($sformatf("run_ones_%0d", v), ones, tv[v].ones);
    end
    n = 0;
    while (lvl3 != 7'd96 && n < 3000) begin
      edge1();
      n++;
    end
    chk("div3_level", lvl3, 96);
    repeat (6) edge1();
    ones = 0; first = -1; badpos = 0; prev = dac3;
    for (int i = 0; i < 384; i++) begin
      edge1();
      ones += dac3;
      if (dac3 != prev) begin
        if (first < 0) first = i;
        else if ((i - first) % 3 != 0) badpos++;
      end
      prev = dac3;
    end
    chk("div3_ones", ones, 288);
    chk("div3_off_tick_changes", badpos, 0);
    chk("div3_has_changes", int'(first >= 0), 1);
    sample_in = 7'd100;
    repeat (4) edge1();
    chk("pre_mute_level", level, 100);
    mute = 1'b1;
    for (n = 1; n <= 500; n++) begin
      edge1();
      if (n == 1) chk("mute_busy", ramp_busy, 1);
      if (level == 7'd0) break;
    end
    chk("ramp_down_ticks", n, 401);
    chk("silent_busy", ramp_busy, 0);
    repeat (2) edge1();
    ones = 0;
    for (int i = 0; i < 200; i++) begin
      edge1();
      ones += dac_out;
    end
    chk("silent_ones", ones, 0);
    mute = 1'b0;
    for (n = 1; n <= 400; n++) begin
      edge1();
      if (level == 7'd64) break;
    end
    chk("reramp_ticks", n, 257);
    repeat (3) edge1();
    mute = 1'b1;
    for (n = 1; n <= 400; n++) begin
      edge1();
      if (level == 7'd50) break;
    end
    chk("down_to_50", level, 50);
    mute = 1'b0;
    mn = 127;
    for (n = 1; n <= 200; n++) begin
      edge1();
      if (level < mn) mn = level;
      if (level == 7'd64) break;
    end
    chk("interrupt_ticks", n, 57);
    chk("interrupt_min", mn, 50);
    sample_in = 7'd127;
    repeat (4) edge1();
    n = 0;
    while (dac_out != 1'b1 && n < 10) begin
      edge1();
      n++;
    end
    chk("pre_reset_dac", dac_out, 1);
    #2 reset_l = 1'b0;
    #1;
    chk("async_level", level, 0);
    chk("async_dac", dac_out, 0);
    chk("async_busy", ramp_busy, 0);
    chk("async_level3", lvl3, 0);
    #10 reset_l = 1'b1;
    edge1();
    chk("restart_busy", ramp_busy, 1);
    chk("restart_level0", level, 0);
    repeat (4) edge1();
    chk("restart_level1", level, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
